// File: rtl/ex_mem_pipe_stage.sv
// ---------------------------------------------------------------------------
// ex_mem_pipe_stage
//   Elastic EX->MEM pipeline register. Holds up to two entries (head + skid)
//   behind a valid/ready handshake so EX can keep issuing for one cycle after
//   MEM stalls. Supports a synchronous flush and bubble (NOP) insertion.
//
//   Optional build macro: EXMEM_FWD_EN adds fwd_en / fwd_reg / fwd_data,
//   combinational views of the head entry for the EX forwarding unit.
//
// Ports
//   clk            clock, all state changes on rising edge
//   rst            asynchronous, active-low reset
//   flush          synchronous squash of every held entry (beats push/pop)
//   in_valid       EX presents an entry
//   in_ready       stage can accept; registered, never depends on out_ready
//   in_nop         accept the entry as a bubble (control bits stored as 0)
//   in_alu_result  ALU result / memory address
//   in_write_reg   destination register
//   in_store_data  store data
//   in_reg_write, in_mem_read, in_mem_write, in_mem_to_reg  control bits
//   out_valid      head entry valid to MEM
//   out_ready      MEM consumes head
//   out_*          head entry fields; controls forced 0 while out_valid=0
//   occupancy      entries held (0..2)
// ---------------------------------------------------------------------------
module ex_mem_pipe_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_nop,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [REG_W-1:0]  in_write_reg,
  input  logic [DATA_W-1:0] in_store_data,
  input  logic              in_reg_write,
  input  logic              in_mem_read,
  input  logic              in_mem_write,
  input  logic              in_mem_to_reg,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_alu_result,
  output logic [REG_W-1:0]  out_write_reg,
  output logic [DATA_W-1:0] out_store_data,
  output logic              out_reg_write,
  output logic              out_mem_read,
  output logic              out_mem_write,
  output logic              out_mem_to_reg,
  output logic [1:0]        occupancy
`ifdef EXMEM_FWD_EN
  ,
  output logic              fwd_en,
  output logic [REG_W-1:0]  fwd_reg,
  output logic [DATA_W-1:0] fwd_data
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } stageState_t;

  stageState_t stateQ, stateD;
  logic        readyQ;

  // Control bits packed as {reg_write, mem_read, mem_write, mem_to_reg}.
  logic [DATA_W-1:0] headAlu, headStore, skidAlu, skidStore;
  logic [REG_W-1:0]  headReg, skidReg;
  logic [3:0]        headCtrl, skidCtrl, inCtrl, gatedCtrl;

  logic push, pop, outValid;
  logic loadHeadIn, loadHeadSkid, loadSkid;

  assign outValid = (stateQ != EMPTY);
  assign push     = in_valid & readyQ;
  assign pop      = outValid & out_ready;
  assign inCtrl   = in_nop ? 4'b0000
                           : {in_reg_write, in_mem_read, in_mem_write, in_mem_to_reg};

  // Next-state and load selects.
  always_comb begin
    stateD       = stateQ;
    loadHeadIn   = 1'b0;
    loadHeadSkid = 1'b0;
    loadSkid     = 1'b0;
    if (flush) begin
      stateD = EMPTY;
    end else begin
      case (stateQ)
        EMPTY: begin
          if (push) begin
            stateD     = HALF;
            loadHeadIn = 1'b1;
          end
        end
        HALF: begin
          if (push && !pop) begin
            stateD   = FULL;
            loadSkid = 1'b1;
          end else if (push && pop) begin
            loadHeadIn = 1'b1;
          end else if (pop) begin
            stateD = EMPTY;
          end
        end
        FULL: begin
          // readyQ is low here, so no push can arrive; the skid moves up.
          if (pop) begin
            stateD       = HALF;
            loadHeadSkid = 1'b1;
          end
        end
        default: stateD = EMPTY;
      endcase
    end
  end

  // in_ready is computed from the next state so it is a pure flop output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateQ <= EMPTY;
      readyQ <= 1'b1;
    end else begin
      stateQ <= stateD;
      readyQ <= (stateD != FULL);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      headAlu   <= '0;
      headReg   <= '0;
      headStore <= '0;
      headCtrl  <= '0;
      skidAlu   <= '0;
      skidReg   <= '0;
      skidStore <= '0;
      skidCtrl  <= '0;
    end else if (flush) begin
      // Data fields are left as they are; only the controls are squashed.
      headCtrl <= '0;
      skidCtrl <= '0;
    end else begin
      if (loadHeadIn) begin
        headAlu   <= in_alu_result;
        headReg   <= in_write_reg;
        headStore <= in_store_data;
        headCtrl  <= inCtrl;
      end else if (loadHeadSkid) begin
        headAlu   <= skidAlu;
        headReg   <= skidReg;
        headStore <= skidStore;
        headCtrl  <= skidCtrl;
      end
      if (loadSkid) begin
        skidAlu   <= in_alu_result;
        skidReg   <= in_write_reg;
        skidStore <= in_store_data;
        skidCtrl  <= inCtrl;
      end
    end
  end

  // Controls must read 0 whenever the head is not valid, even if the
  // head register still holds a stale entry.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : gCtrlGate
      assign gatedCtrl[gi] = headCtrl[gi] & outValid;
    end
  endgenerate

  assign in_ready       = readyQ;
  assign out_valid      = outValid;
  assign out_alu_result = headAlu;
  assign out_write_reg  = headReg;
  assign out_store_data = headStore;
  assign out_reg_write  = gatedCtrl[3];
  assign out_mem_read   = gatedCtrl[2];
  assign out_mem_write  = gatedCtrl[1];
  assign out_mem_to_reg = gatedCtrl[0];
  assign occupancy      = stateQ;

`ifdef EXMEM_FWD_EN
  assign fwd_en   = outValid & headCtrl[3] & ~headCtrl[0] & (headReg != '0);
  assign fwd_reg  = headReg;
  assign fwd_data = headAlu;
`endif

endmodule

// File: tb/tb_ex_mem_pipe_stage.sv
module tb_ex_mem_pipe_stage;

  typedef struct packed {
    logic [31:0] alu;
    logic [4:0]  wr;
    logic [31:0] sd;
    logic [3:0]  ctrl;  // {reg_write, mem_read, mem_write, mem_to_reg}
  } entry_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        inValid = 1'b0;
  logic        inNop = 1'b0;
  logic        outReady = 1'b1;
  entry_t      inEntry = '0;

  logic        in_ready, out_valid;
  logic [31:0] out_alu_result, out_store_data;
  logic [4:0]  out_write_reg;
  logic        out_reg_write, out_mem_read, out_mem_write, out_mem_to_reg;
  logic [1:0]  occupancy;
  logic [3:0]  ctrlOut;
`ifdef EXMEM_FWD_EN
  logic        fwd_en;
  logic [4:0]  fwd_reg;
  logic [31:0] fwd_data;
`endif

  assign ctrlOut = {out_reg_write, out_mem_read, out_mem_write, out_mem_to_reg};

  always #5 clk = ~clk;

  ex_mem_pipe_stage #(.DATA_W(32), .REG_W(5)) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .in_valid(inValid),
    .in_ready(in_ready),
    .in_nop(inNop),
    .in_alu_result(inEntry.alu),
    .in_write_reg(inEntry.wr),
    .in_store_data(inEntry.sd),
    .in_reg_write(inEntry.ctrl[3]),
    .in_mem_read(inEntry.ctrl[2]),
    .in_mem_write(inEntry.ctrl[1]),
    .in_mem_to_reg(inEntry.ctrl[0]),
    .out_valid(out_valid),
    .out_ready(outReady),
    .out_alu_result(out_alu_result),
    .out_write_reg(out_write_reg),
    .out_store_data(out_store_data),
    .out_reg_write(out_reg_write),
    .out_mem_read(out_mem_read),
    .out_mem_write(out_mem_write),
    .out_mem_to_reg(out_mem_to_reg),
    .occupancy(occupancy)
`ifdef EXMEM_FWD_EN
    ,
    .fwd_en(fwd_en),
    .fwd_reg(fwd_reg),
    .fwd_data(fwd_data)
`endif
  );

  int     vectors = 0;
  int     miscompares = 0;
  entry_t mq[$];
  logic   accepted = 1'b0;

  task automatic checkVal(input string tag, input logic [79:0] got, input logic [79:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: check outputs at the falling edge against the model, then
  // advance the model with the inputs seen at the rising edge.
  task automatic cycle();
    entry_t h;
    entry_t stored;
    logic   expValid, popNow, pushNow;
    @(negedge clk);
    expValid = (mq.size() > 0);
    checkVal("in_ready", 80'(in_ready), 80'(mq.size() < 2));
    checkVal("occupancy", 80'(occupancy), 80'(mq.size()));
    checkVal("out_valid", 80'(out_valid), 80'(expValid));
    if (expValid) begin
      h = mq[0];
      checkVal("head", 80'({out_alu_result, out_write_reg, out_store_data, ctrlOut}), 80'(h));
      if (outReady)
        $display("pop alu=%08h wr=%0d sd=%08h ctrl=%04b", out_alu_result, out_write_reg,
                 out_store_data, ctrlOut);
    end else begin
      checkVal("ctrl_idle", 80'(ctrlOut), 80'(0));
    end
`ifdef EXMEM_FWD_EN
    begin
      logic expFwd;
      expFwd = expValid && mq[0].ctrl[3] && !mq[0].ctrl[0] && (mq[0].wr != 5'd0);
      checkVal("fwd_en", 80'(fwd_en), 80'(expFwd));
      if (expValid) begin
        checkVal("fwd_reg", 80'(fwd_reg), 80'(mq[0].wr));
        checkVal("fwd_data", 80'(fwd_data), 80'(mq[0].alu));
      end
    end
`endif
    @(posedge clk);
    stored = inEntry;
    if (inNop) stored.ctrl = 4'b0000;
    accepted = 1'b0;
    if (flush) begin
      mq.delete();
    end else begin
      popNow  = (mq.size() > 0) && outReady;
      pushNow = inValid && (mq.size() < 2);
      if (popNow) void'(mq.pop_front());
      if (pushNow) mq.push_back(stored);
      accepted = pushNow;
    end
    #1;
  endtask

  task automatic sendEntry(input entry_t e, input logic nop);
    int n;
    inValid = 1'b1;
    inEntry = e;
    inNop   = nop;
    n = 0;
    accepted = 1'b0;
    while (!accepted && n < 20) begin
      cycle();
      n++;
    end
    if (!accepted) checkVal("push_timeout", 80'(1), 80'(0));
    inValid = 1'b0;
    inNop   = 1'b0;
  endtask

  function automatic entry_t mk(input logic [31:0] alu, input logic [4:0] wr,
                                input logic [31:0] sd, input logic [3:0] ctrl);
    entry_t e;
    e.alu = alu; e.wr = wr; e.sd = sd; e.ctrl = ctrl;
    return e;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #2;
    checkVal("rst_in_ready", 80'(in_ready), 80'(1));
    checkVal("rst_out_valid", 80'(out_valid), 80'(0));
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    cycle();

    // Single push latency and back-to-back throughput
    outReady = 1'b1;
    sendEntry(mk(32'h0000_1234, 5'd5, 32'h5555_0000, 4'b1000), 1'b0);
    cycle();
    for (int i = 0; i < 10; i++) begin
      inValid = 1'b1;
      inEntry = mk(32'h100 + 32'(i), 5'(i + 1), 32'hCAFE_0000 + 32'(i), 4'(i));
      cycle();
      if (!accepted) checkVal("b2b_accept", 80'(0), 80'(1));
    end
    inValid = 1'b0;
    repeat (3) cycle();

    // Back-pressure: A, B fill the stage, C waits, then all drain in order
    outReady = 1'b0;
    sendEntry(mk(32'hA, 5'd1, 32'h1A, 4'b1000), 1'b0);
    sendEntry(mk(32'hB, 5'd2, 32'h1B, 4'b0100), 1'b0);
    inValid = 1'b1;
    inEntry = mk(32'hC, 5'd3, 32'h1C, 4'b0010);
    repeat (2) cycle();
    outReady = 1'b1;
    sendEntry(mk(32'hC, 5'd3, 32'h1C, 4'b0010), 1'b0);
    repeat (3) cycle();

    // Bubble insertion
    sendEntry(mk(32'h40, 5'd9, 32'h77, 4'b1010), 1'b1);
    repeat (2) cycle();

    // Asynchronous reset while full
    outReady = 1'b0;
    sendEntry(mk(32'h11, 5'd4, 32'h21, 4'b1111), 1'b0);
    sendEntry(mk(32'h12, 5'd6, 32'h22, 4'b1101), 1'b0);
    cycle();
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    checkVal("arst_out_valid", 80'(out_valid), 80'(0));
    checkVal("arst_outs", 80'({out_alu_result, out_write_reg, out_store_data, ctrlOut}), 80'(0));
    checkVal("arst_occupancy", 80'(occupancy), 80'(0));
    checkVal("arst_in_ready", 80'(in_ready), 80'(1));
    mq.delete();
    inValid = 1'b1;
    inEntry = mk(32'h33, 5'd7, 32'h44, 4'b1000);
    @(posedge clk); #1;
    checkVal("rst_no_push", 80'(out_valid), 80'(0));
    @(negedge clk);
    rst = 1'b0;
    inValid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    outReady = 1'b1;
    cycle();

    // Flush while full with a push presented
    outReady = 1'b0;
    sendEntry(mk(32'h21, 5'd8, 32'h31, 4'b1000), 1'b0);
    sendEntry(mk(32'h22, 5'd8, 32'h32, 4'b1000), 1'b0);
    flush = 1'b1;
    inValid = 1'b1;
    inEntry = mk(32'hF, 5'd15, 32'hF, 4'b1111);
    cycle();
    flush = 1'b0;
    inValid = 1'b0;
    repeat (2) cycle();

    // Flush while half full: the push that would otherwise be taken is dropped
    sendEntry(mk(32'h23, 5'd9, 32'h33, 4'b0100), 1'b0);
    flush = 1'b1;
    inValid = 1'b1;
    inEntry = mk(32'hF, 5'd15, 32'hF, 4'b1111);
    cycle();
    flush = 1'b0;
    inValid = 1'b0;
    outReady = 1'b1;
    repeat (2) cycle();

    // Forwarding view of the head (checked inside cycle when enabled)
    outReady = 1'b0;
    sendEntry(mk(32'h55, 5'd0, 32'h0, 4'b1000), 1'b0);
    outReady = 1'b1;
    cycle();
    outReady = 1'b0;
    sendEntry(mk(32'h99, 5'd7, 32'h0, 4'b1000), 1'b0);
    outReady = 1'b1;
    cycle();
    outReady = 1'b0;
    sendEntry(mk(32'h99, 5'd7, 32'h0, 4'b1001), 1'b0);
    outReady = 1'b1;
    repeat (2) cycle();

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      outReady = 1'($urandom_range(0, 1));
      inValid  = 1'($urandom_range(0, 1));
      inNop    = ($urandom_range(0, 3) == 0);
      flush    = ($urandom_range(0, 19) == 0);
      inEntry  = mk($urandom, 5'($urandom), $urandom, 4'($urandom));
      cycle();
    end
    flush = 1'b0;
    inValid = 1'b0;
    inNop = 1'b0;
    outReady = 1'b1;
    repeat (3) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
